// File: rtl/alu_pkg.sv
// Shared ALU control encodings and execute-unit FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  typedef enum logic {
    StIdle,
    StShift
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the ALU execute unit.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               InValid;
  logic               InReady;
  logic [2:0]         ALUControl;
  logic               shift;
  logic [WIDTH-1:0]   SrcA;
  logic [WIDTH-1:0]   SrcB;
  logic [SHAMT_W-1:0] Shamt;
  logic [WIDTH-1:0]   Result;
  logic               Zero;
  logic               OutValid;
  logic               Stall;

  modport master (
    output InValid, ALUControl, shift, SrcA, SrcB, Shamt,
    input  InReady, Result, Zero, OutValid, Stall
  );

  modport slave (
    input  InValid, ALUControl, shift, SrcA, SrcB, Shamt,
    output InReady, Result, Zero, OutValid, Stall
  );
endinterface

// File: rtl/serial_shifter.sv
// One-bit-per-cycle logical shifter; done flags the cycle whose shifted value is final.
module serial_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               right,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WIDTH-1:0]   shifted,
  output logic               done
);

  logic [WIDTH-1:0]   shreg_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               right_q;

  assign shifted = right_q ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
  assign done    = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
    end else if (load) begin
      shreg_q <= din;
      cnt_q   <= amount;
      right_q <= right;
    end else if (cnt_q != '0) begin
      shreg_q <= shifted;
      cnt_q   <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle logic/arithmetic ops, serial SLL/SRL that raises Stall.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;
  logic             stall_q;

  logic             accept;
  logic             shift_op;
  logic             start_shift;
  logic             shift_done;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] alu_res;

  assign accept   = bus.InValid && (state_q == StIdle);
  // Only a consistent decode (shift flag plus SLL/SRL code) is a real shift.
  assign shift_op = bus.shift && ((bus.ALUControl == ALU_SLL) || (bus.ALUControl == ALU_SRL));

  always_comb begin
    alu_res = '0;
    if (bus.shift) begin
      if (shift_op) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        alu_res = bus.ALUControl[0] ? (bus.SrcB >> bus.Shamt) : (bus.SrcB << bus.Shamt);
`else
        alu_res = bus.SrcB;
`endif
      end
    end else begin
      case (bus.ALUControl)
        ALU_ADD: alu_res = bus.SrcA + bus.SrcB;
        ALU_SUB: alu_res = bus.SrcA - bus.SrcB;
        ALU_AND: alu_res = bus.SrcA & bus.SrcB;
        ALU_OR:  alu_res = bus.SrcA | bus.SrcB;
        ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
        default: alu_res = '0;
      endcase
    end
  end

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign start_shift = 1'b0;
  assign shift_done  = 1'b0;
  assign shifted     = '0;
`else
  // A zero shift amount completes through the single-cycle path instead.
  assign start_shift = accept && shift_op && (bus.Shamt != '0);

  serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (start_shift),
    .right   (bus.ALUControl[0]),
    .din     (bus.SrcB),
    .amount  (bus.Shamt),
    .shifted (shifted),
    .done    (shift_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (start_shift) begin
              state_q <= StShift;
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        StShift: begin
          if (shift_done) begin
            result_q    <= shifted;
            zero_q      <= (shifted == '0);
            out_valid_q <= 1'b1;
            stall_q     <= 1'b0;
            state_q     <= StIdle;
          end else begin
            stall_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.InReady  = (state_q == StIdle);
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.OutValid = out_valid_q;
  assign bus.Stall    = stall_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, corner sequences, random vs. model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bif ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  ctl;
    logic        sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  amt;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: result straight from the instruction semantics.
  function automatic logic [31:0] model_res(input logic [2:0] ctl, input logic sh,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] amt);
    if (sh) begin
      if (ctl == 3'b100) return b << amt;
      if (ctl == 3'b101) return b >> amt;
      return 32'h0;
    end
    case (ctl)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Reference: cycles spent busy (InReady low) before the result appears.
  function automatic int model_busy(input logic [2:0] ctl, input logic sh, input logic [4:0] amt);
`ifdef ALU_EXEC_FAST_SHIFT_EN
    return 0;
`else
    if (sh && (ctl == 3'b100 || ctl == 3'b101)) return int'(amt);
    return 0;
`endif
  endfunction

  task automatic drive(input logic [2:0] ctl, input logic sh, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] amt);
    bif.InValid    = 1'b1;
    bif.ALUControl = ctl;
    bif.shift      = sh;
    bif.SrcA       = a;
    bif.SrcB       = b;
    bif.Shamt      = amt;
  endtask

  // Issue one op and wait (bounded) for OutValid; returns in the OutValid cycle.
  task automatic run_op(input logic [2:0] ctl, input logic sh, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] amt,
                        output logic [31:0] res, output logic z, output int busy,
                        output int stalls, output bit ok);
    drive(ctl, sh, a, b, amt);
    @(posedge clk); #1;
    bif.InValid = 1'b0;
    busy = 0; stalls = 0; ok = 1'b0; res = 32'h0; z = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bif.OutValid) begin
        ok = 1'b1; res = bif.Result; z = bif.Zero;
        break;
      end
      if (!bif.InReady) busy++;
      if (bif.Stall) stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply(input string tag, input logic [2:0] ctl, input logic sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] amt,
                       input logic [31:0] exp_res, input logic exp_zero);
    logic [31:0] res;
    logic        z;
    int          busy, stalls, eb;
    bit          ok;
    run_op(ctl, sh, a, b, amt, res, z, busy, stalls, ok);
    eb = model_busy(ctl, sh, amt);
    chk_int({tag, ".outvalid_seen"}, int'(ok), 1);
    chk({tag, ".result"}, res, exp_res);
    chk({tag, ".zero"}, 32'(z), 32'(exp_zero));
    chk_int({tag, ".busy_cycles"}, busy, eb);
    chk_int({tag, ".stall_cycles"}, stalls, (eb > 0) ? eb - 1 : 0);
  endtask

  initial begin
    logic [2:0]  rctl;
    logic        rsh;
    logic [31:0] ra, rb, er;
    logic [4:0]  ramt;
    int          busy, ov_count;

    tbl[0]  = '{3'b010, 1'b0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};
    tbl[1]  = '{3'b110, 1'b0, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1};
    tbl[2]  = '{3'b111, 1'b0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
    tbl[3]  = '{3'b100, 1'b1, 32'h00000000, 32'h00000003, 5'd4,  32'h00000030, 1'b0};
    tbl[4]  = '{3'b101, 1'b1, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
    tbl[5]  = '{3'b101, 1'b1, 32'h00000000, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    tbl[6]  = '{3'b000, 1'b0, 32'h0000F0F0, 32'h0000FF00, 5'd3,  32'h0000F000, 1'b0};
    tbl[7]  = '{3'b001, 1'b0, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 1'b0};
    tbl[8]  = '{3'b011, 1'b0, 32'h12345678, 32'h11111111, 5'd0,  32'h00000000, 1'b1};
    tbl[9]  = '{3'b010, 1'b1, 32'h00000001, 32'h00000002, 5'd5,  32'h00000000, 1'b1};
    tbl[10] = '{3'b100, 1'b0, 32'h00000001, 32'h00000002, 5'd5,  32'h00000000, 1'b1};
    tbl[11] = '{3'b111, 1'b0, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1};

    reset = 1'b1;
    bif.InValid = 1'b0; bif.ALUControl = 3'b000; bif.shift = 1'b0;
    bif.SrcA = 32'h0; bif.SrcB = 32'h0; bif.Shamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", bif.Result, 32'h0);
    chk("reset.zero", 32'(bif.Zero), 32'h1);
    chk("reset.outvalid", 32'(bif.OutValid), 32'h0);
    chk("reset.stall", 32'(bif.Stall), 32'h0);
    chk("reset.inready", 32'(bif.InReady), 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].ctl, tbl[i].sh, tbl[i].a, tbl[i].b, tbl[i].amt,
            tbl[i].res, tbl[i].zero);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.pulse_end", i), 32'(bif.OutValid), 32'h0);
      chk($sformatf("tbl%0d.result_hold", i), bif.Result, tbl[i].res);
      chk($sformatf("tbl%0d.zero_hold", i), 32'(bif.Zero), 32'(tbl[i].zero));
    end

    // Reset in the middle of a long shift: no result, registers back to reset state.
    apply("pre_reset_add", 3'b010, 1'b0, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
    drive(3'b100, 1'b1, 32'h0, 32'h1, 5'd10);
    @(posedge clk); #1;
    bif.InValid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset.result", bif.Result, 32'h0);
    chk("midreset.zero", 32'(bif.Zero), 32'h1);
    chk("midreset.inready", 32'(bif.InReady), 32'h1);
    chk("midreset.stall", 32'(bif.Stall), 32'h0);
    ov_count = 0;
    for (int i = 0; i < 15; i++) begin
      if (bif.OutValid) ov_count++;
      @(posedge clk); #1;
    end
    chk_int("midreset.no_outvalid", ov_count, 0);

    // InValid held through a shift, then an ADD accepted in the OutValid cycle.
    drive(3'b100, 1'b1, 32'h0, 32'h5, 5'd3);
    @(posedge clk); #1;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.OutValid) break;
      if (!bif.InReady) busy++;
      @(posedge clk); #1;
    end
    chk("b2b.outvalid_seen", 32'(bif.OutValid), 32'h1);
    chk_int("b2b.busy_cycles", busy, model_busy(3'b100, 1'b1, 5'd3));
    chk("b2b.shift_result", bif.Result, 32'h28);
    drive(3'b010, 1'b0, 32'd2, 32'd3, 5'd0);
    @(posedge clk); #1;
    bif.InValid = 1'b0;
    chk("b2b.add_outvalid", 32'(bif.OutValid), 32'h1);
    chk("b2b.add_result", bif.Result, 32'd5);
    @(posedge clk); #1;
    chk("b2b.no_extra", 32'(bif.OutValid), 32'h0);

    // Random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      rctl = 3'($urandom_range(0, 7));
      if (rctl == 3'b100 || rctl == 3'b101) rsh = ($urandom_range(0, 7) != 0);
      else rsh = ($urandom_range(0, 7) == 0);
      ra   = $urandom;
      rb   = ($urandom_range(0, 9) == 0) ? ra : $urandom;
      ramt = 5'($urandom_range(0, 31));
      er   = model_res(rctl, rsh, ra, rb, ramt);
      apply($sformatf("rnd%0d", n), rctl, rsh, ra, rb, ramt, er, (er == 32'h0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
